i2c_target: RTL

// - I2C target (slave) endpoint answering the i2c_controller master on the same two-wire bus.
// - Decodes START/STOP, matches a fixed 7-bit address and ACKs it.
// - Write transfers: delivers received bytes to local logic. Read transfers: fetches bytes from local logic and serialises them.
// - Sits at the far end of the bus. Top level builds the open-drain pad: sda = sda_oe ? 1'b0 : 1'bz; SCL is input only, no clock stretching.

---
 rtl/i2c_pkg.sv | 18 +
 rtl/i2c_bus_sync.sv | 47 ++++
 rtl/i2c_target.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target endpoint.
package i2c_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK,
        S_IGNORE
    } i2c_state_e;

    localparam logic I2C_RW_READ = 1'b1;
    localparam logic I2C_ACK     = 1'b0;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into the clk domain and decodes edges and START/STOP
// from the synchronised values and one history flop per line.
module i2c_bus_sync #(
    parameter int SYNC_LEN = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_LEN-1:0] r_scl_sync;
    logic [SYNC_LEN-1:0] r_sda_sync;
    logic                r_scl_hist;
    logic                r_sda_hist;
    logic                w_scl_s;
    logic                w_sda_s;

    // Flops reset to the idle-bus level so reset release creates no edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_hist <= 1'b1;
            r_sda_hist <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_LEN-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_LEN-2:0], sda_in};
            r_scl_hist <= w_scl_s;
            r_sda_hist <= w_sda_s;
        end
    end

    assign w_scl_s   = r_scl_sync[SYNC_LEN-1];
    assign w_sda_s   = r_sda_sync[SYNC_LEN-1];
    assign sda_s     = w_sda_s;
    assign scl_rise  =  w_scl_s & ~r_scl_hist;
    assign scl_fall  = ~w_scl_s &  r_scl_hist;
    assign start_det =  w_scl_s &  r_scl_hist &  r_sda_hist & ~w_sda_s;
    assign stop_det  =  w_scl_s &  r_scl_hist & ~r_sda_hist &  w_sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, byte receive with ACK, byte transmit on request.
// SDA is open-drain: sda_oe=1 pulls the line low.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR     = 7'h55,
    parameter int         SYNC_LEN = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       rw_dir
);

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;
    logic w_sda_s;

    i2c_bus_sync #(.SYNC_LEN(SYNC_LEN)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .start_det (w_start),
        .stop_det  (w_stop),
        .sda_s     (w_sda_s)
    );

    i2c_state_e r_state,     w_state_nxt;
    logic [7:0] r_shift,     w_shift_nxt;
    logic [2:0] r_bit_cnt,   w_bit_cnt_nxt;
    logic       r_byte_full, w_byte_full_nxt;
    logic       r_ack_ok,    w_ack_ok_nxt;
    logic       r_sda_oe,    w_sda_oe_nxt;
    logic [7:0] r_rx_data,   w_rx_data_nxt;
    logic       r_rx_valid,  w_rx_valid_nxt;
    logic       r_tx_req,    w_tx_req_nxt;
    logic       r_busy,      w_busy_nxt;
    logic       r_rw_dir,    w_rw_dir_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_shift     <= 8'h00;
            r_bit_cnt   <= 3'd0;
            r_byte_full <= 1'b0;
            r_ack_ok    <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_tx_req    <= 1'b0;
            r_busy      <= 1'b0;
            r_rw_dir    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_byte_full <= w_byte_full_nxt;
            r_ack_ok    <= w_ack_ok_nxt;
            r_sda_oe    <= w_sda_oe_nxt;
            r_rx_data   <= w_rx_data_nxt;
            r_rx_valid  <= w_rx_valid_nxt;
            r_tx_req    <= w_tx_req_nxt;
            r_busy      <= w_busy_nxt;
            r_rw_dir    <= w_rw_dir_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        // tx_data is captured the clk after tx_req; never coincides with an SCL edge.
        w_shift_nxt     = r_tx_req ? tx_data : r_shift;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_byte_full_nxt = r_byte_full;
        w_ack_ok_nxt    = r_ack_ok;
        w_sda_oe_nxt    = r_sda_oe;
        w_rx_data_nxt   = r_rx_data;
        w_rx_valid_nxt  = 1'b0;
        w_tx_req_nxt    = 1'b0;
        w_busy_nxt      = r_busy;
        w_rw_dir_nxt    = r_rw_dir;

        if (w_stop) begin
            w_state_nxt     = S_IDLE;
            w_sda_oe_nxt    = 1'b0;
            w_busy_nxt      = 1'b0;
            w_bit_cnt_nxt   = 3'd0;
            w_byte_full_nxt = 1'b0;
            w_ack_ok_nxt    = 1'b0;
        end else if (w_start) begin
            w_state_nxt     = S_ADDR;
            w_sda_oe_nxt    = 1'b0;
            w_busy_nxt      = 1'b0;
            w_bit_cnt_nxt   = 3'd0;
            w_byte_full_nxt = 1'b0;
            w_ack_ok_nxt    = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: ;

                // Bits counted on SCL rise; the byte completes on the following fall.
                S_ADDR, S_WR_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = {r_shift[6:0], w_sda_s};
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7)
                            w_byte_full_nxt = 1'b1;
                    end else if (w_scl_fall && r_byte_full) begin
                        w_byte_full_nxt = 1'b0;
                        if (r_state == S_ADDR) begin
                            if (r_shift[7:1] == ADDR) begin
                                w_state_nxt  = S_ADDR_ACK;
                                w_sda_oe_nxt = 1'b1;
                                w_busy_nxt   = 1'b1;
                                w_rw_dir_nxt = r_shift[0];
                            end else begin
                                w_state_nxt = S_IGNORE;
                            end
                        end else begin
                            w_rx_data_nxt  = r_shift;
                            w_rx_valid_nxt = 1'b1;
                            w_sda_oe_nxt   = 1'b1;
                            w_state_nxt    = S_WR_ACK;
                        end
                    end
                end

                S_ADDR_ACK: begin
                    if (w_scl_rise && r_rw_dir == I2C_RW_READ) begin
                        w_tx_req_nxt = 1'b1;
                    end else if (w_scl_fall) begin
                        w_bit_cnt_nxt = 3'd0;
                        if (r_rw_dir == I2C_RW_READ) begin
                            w_sda_oe_nxt = ~r_shift[7];
                            w_state_nxt  = S_RD_DATA;
                        end else begin
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = S_WR_DATA;
                        end
                    end
                end

                S_WR_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt = 1'b0;
                        w_state_nxt  = S_WR_DATA;
                    end
                end

                // Bits counted on SCL fall; bit7 is already on the bus at entry.
                S_RD_DATA: begin
                    if (w_scl_fall) begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_sda_oe_nxt = 1'b0;
                            w_ack_ok_nxt = 1'b0;
                            w_state_nxt  = S_RD_ACK;
                        end else begin
                            w_shift_nxt  = {r_shift[6:0], 1'b0};
                            w_sda_oe_nxt = ~r_shift[6];
                        end
                    end
                end

                S_RD_ACK: begin
                    if (w_scl_rise) begin
                        if (w_sda_s == I2C_ACK) begin
                            w_tx_req_nxt = 1'b1;
                            w_ack_ok_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_IGNORE;
                        end
                    end else if (w_scl_fall && r_ack_ok) begin
                        w_ack_ok_nxt  = 1'b0;
                        w_bit_cnt_nxt = 3'd0;
                        w_sda_oe_nxt  = ~r_shift[7];
                        w_state_nxt   = S_RD_DATA;
                    end
                end

                S_IGNORE: w_sda_oe_nxt = 1'b0;

                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign sda_oe   = r_sda_oe;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_req   = r_tx_req;
    assign busy     = r_busy;
    assign rw_dir   = r_rw_dir;

endmodule
